stream_mux_rr: RTL
==================

// Module: stream_mux_rr
// PURPOSE
//  Parametrised N-input, WIDTH-bit registered stream multiplexer with valid/ready handshake.
//  Successor to the lab's fixed 3:1 combinational mux.
//  Selects one channel either by an explicit select or by fair round-robin.
//  Drives a single output register that feeds the ALU operand path.
//  An out-of-range select is defined behaviour: it grants nothing and raises a flag.
// PARAMETERS
//  WIDTH  8  data width per channel, in bits
//  N_IN   3  number of input channels (2..16)
//  SEL_W  2  select/channel-index width; must be >= $clog2(N_IN)
// PORTS
//  clk       in   1            single clock; all state on posedge
//  rst_n     in   1            synchronous reset, active-low
//  mode      in   1            0 = MODE_SEL (explicit sel), 1 = MODE_RR (round-robin)
//  sel       in   SEL_W        channel select, used in MODE_SEL only
//  in_data   in   N_IN*WIDTH   channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid  in   N_IN         per-channel valid
//  in_ready  out  N_IN         per-channel ready; one-hot or all-zero
//  out_data  out  WIDTH        registered output data
//  out_valid out  1            output register holds a beat
//  out_ready in   1            downstream accepts the beat
//  out_ch    out  SEL_W        index of the channel that produced out_data
//  sel_err   out  1            one-cycle pulse: sel >= N_IN while in MODE_SEL
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - out_valid=0, out_data=0, out_ch=0, sel_err=0.
//   - rr_ptr=N_IN-1, so channel 0 has first RR priority.
//  load_en = !out_valid || out_ready. This gives full throughput with 1-cycle latency.
//  Grant, evaluated combinationally each cycle:
//   - MODE_SEL: grant = sel if sel < N_IN and in_valid[sel]; otherwise no grant.
//   - MODE_RR: grant = first i with in_valid[i], scanning rr_ptr+1 .. N_IN-1, then wrapping to 0 .. rr_ptr.
//   - MODE_RR with no in_valid asserted: no grant.
//  in_ready[i] = load_en && grant valid && grant == i.
//  Transfer on input i is in_valid[i] && in_ready[i].
//  On transfer: out_data <= in_data[i], out_ch <= i, out_valid <= 1 at the next edge.
//  Downstream pop without a new transfer (out_ready=1, out_valid=1, no grant):
//   - out_valid <= 0.
//   - out_data and out_ch hold their values.
//  Simultaneous pop and load: the new beat replaces the old one in the same cycle; no bubble.
//  Stall (out_valid=1 && !out_ready): all in_ready=0; out_data/out_ch/out_valid hold.
//  rr_ptr <= grant only on a MODE_RR transfer. MODE_SEL transfers and idle cycles leave rr_ptr unchanged.
//  sel_err <= (mode==MODE_SEL) && (sel >= N_IN) every cycle.
//   - The flag is registered, so the pulse follows the offending cycle.
//   - It is independent of load_en.
//   - No transfer occurs while sel is out of range.
//  Mode change takes effect on the same cycle's grant; no flush is performed.
//  Reset mid-operation: a held beat is discarded; no in_ready is asserted during reset.
//  Inputs must hold in_data/in_valid until accepted.
//  The block never asserts in_ready on a channel with in_valid=0.
// STRUCTURE
//  stream_mux_pkg: MODE_SEL=1'b0, MODE_RR=1'b1 constants; shared by the ALU control.
//  rr_arbiter sub-module (combinational):
//   - ports: req[N_IN], ptr[SEL_W], gnt_vld, gnt_idx[SEL_W].
//   - rotate-priority scan from ptr+1.
//   - instantiated once.
//  Top level contains the MODE_SEL decode, the load_en/in_ready logic, and the output register, rr_ptr and sel_err flops.
// TESTING
//  1. Reset: hold rst_n=0 for 3 cycles with in_valid=3'b111.
//     -> out_valid=0, out_data=0, in_ready=000, sel_err=0.
//  2. MODE_SEL, sel=1, in_data ch1=8'hA5, in_valid=010, out_ready=1.
//     -> next cycle out_valid=1, out_data=A5, out_ch=1; in_ready=010 during the request.
//  3. MODE_SEL, sel=2'b11 (N_IN=3), in_valid=111.
//     -> in_ready=000, sel_err=1 on the next cycle only, out_valid falls after the pop.
//  4. MODE_RR, in_valid=111 held, out_ready=1, data ch0/1/2 = 10/20/30.
//     -> out_ch sequence 0,1,2,0,1,2; one beat per cycle.
//  5. MODE_RR, out_ready=0 for 4 cycles after first beat 8'h10.
//     -> out_data stays 10, in_ready=000.
//     -> On release: next grant is ch1, with no loss or duplication.
//  6. MODE_RR, in_valid=101 only.
//     -> grants alternate 0,2,0,2.
//     -> Switch to MODE_SEL sel=2: ch2 granted repeatedly and rr_ptr holds.
//     -> Back to MODE_RR: resumes after the last RR grant.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared mode encodings for the operand stream mux and the ALU control that drives it.
package stream_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: scans requests starting one past ptr, wrapping around.
module rr_arbiter #(
    parameter int N_IN  = 3,
    parameter int SEL_W = 2
) (
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [SEL_W-1:0] gnt_idx
);

    logic [2*N_IN-1:0] req2;
    logic [N_IN-1:0]   rot;
    int                first;
    int                idx;

    always_comb begin
        req2    = {req, req};
        // Doubling the vector lets a plain right shift act as a rotation by ptr+1.
        rot     = N_IN'(req2 >> (int'(ptr) + 1));
        gnt_vld = |rot;
        first   = 0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            if (rot[k]) first = k;
        end
        idx = int'(ptr) + 1 + first;
        if (idx >= N_IN) idx = idx - N_IN;
        gnt_idx = SEL_W'(idx);
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-input registered stream mux with valid/ready handshake, explicit-select or round-robin grant.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_IN  = 3,
    parameter int SEL_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  sel_err
);

    logic [SEL_W-1:0] rr_ptr;
    logic             rr_vld;
    logic [SEL_W-1:0] rr_idx;
    logic             sel_ok;
    logic             sel_hit;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             load_en;
    logic             xfer;

    rr_arbiter #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt_vld (rr_vld),
        .gnt_idx (rr_idx)
    );

    always_comb begin
        sel_ok  = int'(sel) < N_IN;
        sel_hit = 1'b0;
        // Loop compare keeps an out-of-range sel from ever indexing in_valid.
        for (int i = 0; i < N_IN; i++) begin
            if (int'(sel) == i && in_valid[i]) sel_hit = 1'b1;
        end
        if (mode == MODE_SEL) begin
            grant_vld = sel_hit;
            grant_idx = sel;
        end else begin
            grant_vld = rr_vld;
            grant_idx = rr_idx;
        end
        load_en    = !out_valid || out_ready;
        xfer       = rst_n && load_en && grant_vld;
        grant_data = '0;
        in_ready   = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (int'(grant_idx) == i) begin
                grant_data  = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = xfer;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            sel_err   <= 1'b0;
            rr_ptr    <= SEL_W'(N_IN - 1);
        end else begin
            sel_err <= (mode == MODE_SEL) && !sel_ok;
            if (xfer) begin
                out_data  <= grant_data;
                out_ch    <= grant_idx;
                out_valid <= 1'b1;
                if (mode == MODE_RR) rr_ptr <= grant_idx;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
